// File: rtl/game_event_gen_pkg.sv
// Shared types and constants for the lander game event generator.
package game_pkg;

  localparam int COORD_W_DEF = 11;
  localparam int POINTS_W    = 5;
  localparam logic [POINTS_W-1:0] POINTS_FULL = 5'b11111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_INVULN = 2'd1,
    ST_HOLD   = 2'd2,
    ST_DEAD   = 2'd3
  } state_t;

endpackage

// File: rtl/game_event_gen_box_overlap.sv
// Combinational axis-aligned bounding-box overlap test.
// Box A at (i_ax,i_ay) sized AW x AH, box B at (i_bx,i_by) sized BW x BH.
// End coordinates are formed one bit wider than the inputs so boxes near
// the top of the coordinate range never wrap. Touching edges do not overlap.
module box_overlap
  import game_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int AW      = 16,
  parameter int AH      = 16,
  parameter int BW      = 16,
  parameter int BH      = 16
) (
  input  logic [COORD_W-1:0] i_ax,
  input  logic [COORD_W-1:0] i_ay,
  input  logic [COORD_W-1:0] i_bx,
  input  logic [COORD_W-1:0] i_by,
  output logic               o_ov
);

  logic [COORD_W:0] w_ax;
  logic [COORD_W:0] w_ay;
  logic [COORD_W:0] w_bx;
  logic [COORD_W:0] w_by;
  logic [COORD_W:0] w_ax_end;
  logic [COORD_W:0] w_ay_end;
  logic [COORD_W:0] w_bx_end;
  logic [COORD_W:0] w_by_end;

  assign w_ax     = {1'b0, i_ax};
  assign w_ay     = {1'b0, i_ay};
  assign w_bx     = {1'b0, i_bx};
  assign w_by     = {1'b0, i_by};
  assign w_ax_end = w_ax + (COORD_W+1)'(AW);
  assign w_ay_end = w_ay + (COORD_W+1)'(AH);
  assign w_bx_end = w_bx + (COORD_W+1)'(BW);
  assign w_by_end = w_by + (COORD_W+1)'(BH);

  assign o_ov = (w_ax < w_bx_end) && (w_bx < w_ax_end) &&
                (w_ay < w_by_end) && (w_by < w_ay_end);

endmodule

// File: rtl/game_event_gen.sv
// Per-frame event generator: tests the player box against obstacle, target
// and landing pad, and emits one-cycle colission/capture/landed pulses two
// cycles after frame_tick, plus the thermometer-coded points mask.
// Optional feature macro: GAME_EVENT_INVULN_EN (adds the INVULN state and
// frame countdown that suppresses collisions after a hit).
module game_event_gen
  import game_pkg::*;
#(
  parameter int COORD_W       = COORD_W_DEF,
  parameter int PLAYER_W      = 16,
  parameter int PLAYER_H      = 16,
  parameter int OBJ_W         = 16,
  parameter int OBJ_H         = 16,
  parameter int PAD_W         = 48,
  parameter int PAD_H         = 8,
  parameter int INVULN_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  input  logic [COORD_W-1:0] obst_x,
  input  logic [COORD_W-1:0] obst_y,
  input  logic [COORD_W-1:0] tgt_x,
  input  logic [COORD_W-1:0] tgt_y,
  input  logic [COORD_W-1:0] pad_x,
  input  logic [COORD_W-1:0] pad_y,
  input  logic               landing_en,
  input  logic               fail,
  input  logic               lvl_start,
  output logic               colission,
  output logic               capture,
  output logic               landed,
  output logic [4:0]         points,
  output logic               invuln
);

  logic               r_vld_p1;
  logic [COORD_W-1:0] r_plx_p1;
  logic [COORD_W-1:0] r_ply_p1;
  logic [COORD_W-1:0] r_obx_p1;
  logic [COORD_W-1:0] r_oby_p1;
  logic [COORD_W-1:0] r_tgx_p1;
  logic [COORD_W-1:0] r_tgy_p1;
  logic [COORD_W-1:0] r_pdx_p1;
  logic [COORD_W-1:0] r_pdy_p1;
  logic               r_len_p1;

  logic w_ov_obst;
  logic w_ov_tgt;
  logic w_ov_pad;
  logic r_prev_obst;
  logic r_prev_tgt;
  logic r_prev_pad;

  logic w_sup_all;
  logic w_col_blk;
  logic w_land_evt;
  logic w_cap_evt;
  logic w_col_evt;
  logic w_lvl_go;

  state_t r_state;
  state_t w_state_nxt;

  logic                r_colission_p2;
  logic                r_capture_p2;
  logic                r_landed_p2;
  logic [POINTS_W-1:0] r_points;

  // ---- Stage 1: capture frame positions on frame_tick ----

  // Valid flag for the frame held in stage 1; reset drops in-flight frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= frame_tick;
    end
  end

  // Position and landing-enable sample; a closer tick simply overwrites it.
  always_ff @(posedge clk) begin
    if (frame_tick) begin
      r_plx_p1 <= player_x;
      r_ply_p1 <= player_y;
      r_obx_p1 <= obst_x;
      r_oby_p1 <= obst_y;
      r_tgx_p1 <= tgt_x;
      r_tgy_p1 <= tgt_y;
      r_pdx_p1 <= pad_x;
      r_pdy_p1 <= pad_y;
      r_len_p1 <= landing_en;
    end
  end

  // ---- Stage 2: overlap compare and event qualification ----

  box_overlap #(
    .COORD_W(COORD_W), .AW(PLAYER_W), .AH(PLAYER_H), .BW(OBJ_W), .BH(OBJ_H)
  ) u_ov_obst (
    .i_ax(r_plx_p1), .i_ay(r_ply_p1), .i_bx(r_obx_p1), .i_by(r_oby_p1),
    .o_ov(w_ov_obst)
  );

  box_overlap #(
    .COORD_W(COORD_W), .AW(PLAYER_W), .AH(PLAYER_H), .BW(OBJ_W), .BH(OBJ_H)
  ) u_ov_tgt (
    .i_ax(r_plx_p1), .i_ay(r_ply_p1), .i_bx(r_tgx_p1), .i_by(r_tgy_p1),
    .o_ov(w_ov_tgt)
  );

  box_overlap #(
    .COORD_W(COORD_W), .AW(PLAYER_W), .AH(PLAYER_H), .BW(PAD_W), .BH(PAD_H)
  ) u_ov_pad (
    .i_ax(r_plx_p1), .i_ay(r_ply_p1), .i_bx(r_pdx_p1), .i_by(r_pdy_p1),
    .o_ov(w_ov_pad)
  );

  // HOLD and DEAD mute everything; a live fail mutes the frame it lands on.
  assign w_sup_all  = (r_state == ST_HOLD) || (r_state == ST_DEAD) || fail;
  assign w_land_evt = r_vld_p1 && w_ov_pad && !r_prev_pad && r_len_p1 &&
                      !w_sup_all;
  // A landing in the same frame wins over capture and collision.
  assign w_cap_evt  = r_vld_p1 && w_ov_tgt && !r_prev_tgt &&
                      (r_points != POINTS_FULL) && !w_sup_all && !w_land_evt;
  assign w_col_evt  = r_vld_p1 && w_ov_obst && !r_prev_obst &&
                      !w_sup_all && !w_land_evt && !w_col_blk;
  assign w_lvl_go   = lvl_start && (r_state == ST_HOLD) && !fail;

  // Previous-frame overlap flags for edge detection; cleared on a new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_obst <= 1'b0;
      r_prev_tgt  <= 1'b0;
      r_prev_pad  <= 1'b0;
    end else if (w_lvl_go) begin
      r_prev_obst <= 1'b0;
      r_prev_tgt  <= 1'b0;
      r_prev_pad  <= 1'b0;
    end else if (r_vld_p1) begin
      r_prev_obst <= w_ov_obst;
      r_prev_tgt  <= w_ov_tgt;
      r_prev_pad  <= w_ov_pad;
    end
  end

`ifdef GAME_EVENT_INVULN_EN
  localparam int CNT_W = $clog2(INVULN_FRAMES + 1);
  logic [CNT_W-1:0] r_cnt;

  assign w_col_blk = (r_state == ST_INVULN);
  assign invuln    = (r_state == ST_INVULN);

  // Invulnerability countdown: load on a hit, count down once per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_col_evt) begin
      r_cnt <= CNT_W'(INVULN_FRAMES - 1);
    end else if (frame_tick && (r_state == ST_INVULN) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (INVULN_FRAMES != 0);
  assign w_col_blk    = 1'b0;
  assign invuln       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; fail forces DEAD ahead of every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (fail) begin
      w_state_nxt = ST_DEAD;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_land_evt) begin
            w_state_nxt = ST_HOLD;
`ifdef GAME_EVENT_INVULN_EN
          end else if (w_col_evt) begin
            w_state_nxt = ST_INVULN;
`endif
          end
        end
        ST_INVULN: begin
`ifdef GAME_EVENT_INVULN_EN
          if (w_land_evt) begin
            w_state_nxt = ST_HOLD;
          end else if (frame_tick && (r_cnt == '0)) begin
            w_state_nxt = ST_RUN;
          end
`else
          w_state_nxt = ST_RUN;
`endif
        end
        ST_HOLD: begin
          if (lvl_start) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DEAD: begin
          w_state_nxt = ST_DEAD;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // ---- Stage 3: registered pulses and points mask ----

  // One-cycle event pulses, high two cycles after the frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_colission_p2 <= 1'b0;
      r_capture_p2   <= 1'b0;
      r_landed_p2    <= 1'b0;
    end else begin
      r_colission_p2 <= w_col_evt;
      r_capture_p2   <= w_cap_evt;
      r_landed_p2    <= w_land_evt;
    end
  end

  // Points mask: lvl_start clears it in any state, a capture shifts in a 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_points <= '0;
    end else if (lvl_start) begin
      r_points <= '0;
    end else if (w_cap_evt) begin
      r_points <= {r_points[POINTS_W-2:0], 1'b1};
    end
  end

  assign colission = r_colission_p2;
  assign capture   = r_capture_p2;
  assign landed    = r_landed_p2;
  assign points    = r_points;

endmodule

// File: tb/tb_game_event_gen.sv
// Self-checking bench for game_event_gen: table of directed frames, hand
// sequences for invulnerability, wrap, fail and mid-pipeline reset, then
// random frames compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_game_event_gen;

`ifdef GAME_EVENT_INVULN_EN
  localparam bit INV_ON = 1'b1;
`else
  localparam bit INV_ON = 1'b0;
`endif
  localparam int FX = 1500;
  localparam int FY = 1800;

  typedef struct {
    int px; int py; int ox; int oy; int tx; int ty; int ax; int ay; bit len;
  } fin_t;

  typedef struct {
    fin_t in; bit col; bit cap; bit land; int pts;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic [10:0] player_x, player_y, obst_x, obst_y, tgt_x, tgt_y, pad_x, pad_y;
  logic        landing_en, fail, lvl_start;
  logic        colission, capture, landed, invuln;
  logic [4:0]  points;

  int errors = 0;
  int checks = 0;

  // reference model state, kept per frame
  bit m_prev_o, m_prev_t, m_prev_p, m_hold, m_dead;
  int m_npts, m_frame, m_inv_end;

  always #5 clk = ~clk;

  game_event_gen dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .player_x(player_x), .player_y(player_y),
    .obst_x(obst_x), .obst_y(obst_y),
    .tgt_x(tgt_x), .tgt_y(tgt_y),
    .pad_x(pad_x), .pad_y(pad_y),
    .landing_en(landing_en), .fail(fail), .lvl_start(lvl_start),
    .colission(colission), .capture(capture), .landed(landed),
    .points(points), .invuln(invuln)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit ovl(int ax, int ay, int aw, int ah,
                             int bx, int by, int bw, int bh);
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  endfunction

  function automatic fin_t mkf(int ox, int oy, int tx, int ty,
                               int ax, int ay, bit len);
    fin_t f;
    f.px = 100; f.py = 100;
    f.ox = ox; f.oy = oy; f.tx = tx; f.ty = ty; f.ax = ax; f.ay = ay;
    f.len = len;
    return f;
  endfunction

  function automatic vec_t mkv(fin_t f, bit col, bit cap, bit land, int pts);
    vec_t v;
    v.in = f; v.col = col; v.cap = cap; v.land = land; v.pts = pts;
    return v;
  endfunction

  task automatic model_reset;
    m_prev_o = 0; m_prev_t = 0; m_prev_p = 0; m_hold = 0; m_dead = 0;
    m_npts = 0; m_frame = 0; m_inv_end = 0;
  endtask

  // Drive one frame, check quiet T+1, outputs at T+2 and quiet T+3.
  task automatic run_frame(input fin_t f, output bit o_col, output bit o_cap,
                           output bit o_land, output bit o_inv);
    bit ovo, ovt, ovp, eo, et, ep, sup, x_land, x_cap, x_col, x_inv;
    int x_pts;
    @(posedge clk); #1;
    player_x = 11'(f.px); player_y = 11'(f.py);
    obst_x = 11'(f.ox); obst_y = 11'(f.oy);
    tgt_x = 11'(f.tx); tgt_y = 11'(f.ty);
    pad_x = 11'(f.ax); pad_y = 11'(f.ay);
    landing_en = f.len;
    frame_tick = 1'b1;
    ovo = ovl(f.px, f.py, 16, 16, f.ox, f.oy, 16, 16);
    ovt = ovl(f.px, f.py, 16, 16, f.tx, f.ty, 16, 16);
    ovp = ovl(f.px, f.py, 16, 16, f.ax, f.ay, 48, 8);
    eo = ovo && !m_prev_o; et = ovt && !m_prev_t; ep = ovp && !m_prev_p;
    m_prev_o = ovo; m_prev_t = ovt; m_prev_p = ovp;
    sup    = m_dead || m_hold;
    x_land = !sup && ep && f.len;
    x_cap  = !sup && !x_land && et && (m_npts < 5);
    x_col  = !sup && !x_land && eo && !(INV_ON && (m_frame < m_inv_end));
    if (x_land) begin m_hold = 1; m_inv_end = 0; end
    if (x_col && INV_ON) m_inv_end = m_frame + 60;
    if (x_cap) m_npts++;
    x_inv = INV_ON && !m_hold && !m_dead && (m_frame < m_inv_end);
    m_frame++;
    x_pts = (1 << m_npts) - 1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    chk("early_pulse", {colission, capture, landed}, 0);
    @(posedge clk); #1;
    o_col = colission; o_cap = capture; o_land = landed; o_inv = invuln;
    chk("colission", colission, x_col);
    chk("capture", capture, x_cap);
    chk("landed", landed, x_land);
    chk("points", points, x_pts);
    chk("invuln", invuln, x_inv);
    @(posedge clk); #1;
    chk("pulse_width", {colission, capture, landed}, 0);
  endtask

  task automatic do_lvl_start;
    @(posedge clk); #1 lvl_start = 1'b1;
    @(posedge clk); #1 lvl_start = 1'b0;
    m_npts = 0;
    if (m_hold && !m_dead) begin
      m_hold = 0; m_prev_o = 0; m_prev_t = 0; m_prev_p = 0; m_inv_end = 0;
    end
    chk("lvl_points", points, 0);
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst_n = 1'b0; frame_tick = 1'b0; lvl_start = 1'b0; fail = 1'b0;
    @(posedge clk); #1;
    chk("reset_out", {colission, capture, landed, invuln, points}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[18];
    fin_t f;
    fin_t far_f;
    bit c, p, l, iv;
    int pts;

    rst_n = 1'b0; frame_tick = 1'b0; lvl_start = 1'b0; fail = 1'b0;
    landing_en = 1'b0;
    player_x = '0; player_y = '0; obst_x = '0; obst_y = '0;
    tgt_x = '0; tgt_y = '0; pad_x = '0; pad_y = '0;
    model_reset();
    do_reset();

    // directed frame table, player fixed at (100,100)
    far_f  = mkf(FX, FX, FX, FX, FX, FY, 0);
    tbl[0] = mkv(mkf(110, 108, FX, FX, FX, FY, 0), 1, 0, 0, 0);
    tbl[1] = mkv(mkf(110, 108, FX, FX, FX, FY, 0), 0, 0, 0, 0);
    tbl[2] = mkv(mkf(116, 100, FX, FX, FX, FY, 0), 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      pts = (k < 5) ? ((1 << (k + 1)) - 1) : 31;
      tbl[3 + 2*k] = mkv(mkf(FX, FX, 90, 95, FX, FY, 0), (k < 5), 0, 0, pts);
      tbl[3 + 2*k].cap = (k < 5);
      tbl[3 + 2*k].col = 0;
      tbl[4 + 2*k] = mkv(far_f, 0, 0, 0, pts);
    end
    tbl[15] = mkv(mkf(FX, FX, FX, FX, 90, 110, 0), 0, 0, 0, 31);
    tbl[16] = mkv(mkf(FX, FX, FX, FX, FX, FY, 1), 0, 0, 0, 31);
    tbl[17] = mkv(mkf(110, 108, FX, FX, 90, 110, 1), 0, 0, 1, 31);
    for (int i = 0; i < 18; i++) begin
      run_frame(tbl[i].in, c, p, l, iv);
      chk($sformatf("tbl%0d_col", i), c, tbl[i].col);
      chk($sformatf("tbl%0d_cap", i), p, tbl[i].cap);
      chk($sformatf("tbl%0d_land", i), l, tbl[i].land);
      chk($sformatf("tbl%0d_pts", i), points, tbl[i].pts);
      if (i == 0) chk("hit_invuln", iv, INV_ON);
    end
    // HOLD until lvl_start, then events run again from a cleared mask
    run_frame(mkf(FX, FX, 90, 95, FX, FY, 0), c, p, l, iv);
    chk("hold_no_cap", p, 0);
    do_lvl_start();
    run_frame(mkf(110, 108, 90, 95, FX, FY, 0), c, p, l, iv);
    chk("run_cap", p, 1);
    chk("run_col", c, 1);
    chk("run_pts", points, 1);

    // invulnerability window: re-hit at frame 30 and at frame 61
    do_reset();
    for (int fr = 0; fr <= 61; fr++) begin
      if (fr == 0 || fr == 30 || fr == 61)
        f = mkf(110, 108, FX, FX, FX, FY, 0);
      else
        f = far_f;
      run_frame(f, c, p, l, iv);
      if (fr == 30) chk("inv_f30_col", c, INV_ON ? 0 : 1);
      if (fr == 61) chk("inv_f61_col", c, 1);
    end

    // coordinates near the top of the range must not wrap
    do_reset();
    f = mkf(5, 5, FX, FX, FX, FY, 0);
    f.px = 2040; f.py = 2040;
    run_frame(f, c, p, l, iv);
    chk("wrap_no_ov", c, 0);
    f = mkf(2040, 2040, FX, FX, FX, FY, 0);
    f.px = 2030; f.py = 2030;
    run_frame(f, c, p, l, iv);
    chk("wrap_hi_ov", c, 1);

    // fail: no events for any overlap
    do_reset();
    @(posedge clk); #1 fail = 1'b1;
    m_dead = 1;
    for (int k = 0; k < 2; k++) begin
      run_frame(mkf(110, 108, 90, 95, 90, 110, 1), c, p, l, iv);
      chk("dead_pulses", {c, p, l}, 0);
    end
    fail = 1'b0;

    // reset pulled during T+1 discards the frame
    do_reset();
    @(posedge clk); #1;
    player_x = 11'd100; player_y = 11'd100; obst_x = 11'd110; obst_y = 11'd108;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_out", {colission, capture, landed, invuln, points}, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_mid_after", {colission, capture, landed}, 0);
    end
    model_reset();

    // random frames against the model
    do_reset();
    for (int n = 0; n < 300; n++) begin
      f.px = int'($urandom_range(150, 50)); f.py = int'($urandom_range(150, 50));
      f.ox = int'($urandom_range(160, 60)); f.oy = int'($urandom_range(160, 60));
      f.tx = int'($urandom_range(160, 60)); f.ty = int'($urandom_range(160, 60));
      f.ax = int'($urandom_range(160, 40)); f.ay = int'($urandom_range(160, 60));
      f.len = 1'($urandom_range(1, 0));
      run_frame(f, c, p, l, iv);
      if ($urandom_range(7, 0) == 0) do_lvl_start();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_event_gen.md
# game_event_gen

Per-frame event generator for the lander game. Each video frame it samples the player, obstacle, target and landing-pad positions and tests the player's bounding box against the other three. It emits single-cycle `colission`, `capture` and `landed` pulses and maintains the 5-bit `points` mask. It sits upstream of the game-state controller and consumes that block's `landing_en` and `fail` outputs.

## Interface
- `COORD_W`, 11: coordinate width (pixels).
- `PLAYER_W` / `PLAYER_H`, 16 / 16: player box size.
- `OBJ_W` / `OBJ_H`, 16 / 16: obstacle and target box size.
- `PAD_W` / `PAD_H`, 48 / 8: landing pad box size.
- `INVULN_FRAMES`, 60: frames of collision suppression after a hit.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_tick` in 1: one-cycle pulse per frame; positions are valid on this cycle.
- `player_x`, `player_y` in COORD_W: player top-left corner.
- `obst_x`, `obst_y` in COORD_W: obstacle top-left corner.
- `tgt_x`, `tgt_y` in COORD_W: target top-left corner.
- `pad_x`, `pad_y` in COORD_W: pad top-left corner.
- `landing_en` in 1: landing allowed, from the game-state controller.
- `fail` in 1: game over, from the game-state controller.
- `lvl_start` in 1: one-cycle pulse that starts a new level.
- `colission` out 1: one-cycle collision pulse.
- `capture` out 1: one-cycle capture pulse.
- `landed` out 1: one-cycle landing pulse.
- `points` out 5: capture mask, thermometer coded from bit 0.
- `invuln` out 1: high while collisions are suppressed.

## Operation
- **Overlap rule.** Boxes A and B overlap iff `ax < bx+BW`, `bx < ax+AW`, `ay < by+BH` and `by < ay+AH`. Sums are computed in COORD_W+1 bits so there is no wrap. Touching edges do not overlap.
- **Edge detection.** Each overlap result is registered per frame. An event qualifies only on a rising edge, i.e. overlap this frame and none the previous frame.
- **States:**
  - RUN: all events are enabled.
  - INVULN: collisions are suppressed; a frame countdown is running.
  - HOLD: entered after `landed`; all events are suppressed until `lvl_start`.
  - DEAD: entered when `fail` is high; all events are suppressed until reset.
- **Transitions:**
  - RUN→INVULN on an emitted `colission`. The counter loads INVULN_FRAMES-1 and decrements on each `frame_tick`. At 0 with `frame_tick` the state returns to RUN.
  - RUN or INVULN→HOLD on `landed`.
  - HOLD→RUN on `lvl_start`. This clears `points` to 0 and clears the previous-overlap registers.
  - Any state→DEAD when `fail`=1. DEAD has priority over every other transition.
- **Capture.** A capture qualifies when the target edge is seen and `points` != 5'b11111. It shifts in a 1: `points <= {points[3:0],1'b1}`. When `points` is full, the capture is dropped and no pulse is emitted.
- **Landing.** A landing qualifies when the pad edge is seen and `landing_en`=1. With `landing_en`=0, pad overlap is ignored but its edge register still updates.
- **Same-frame events:**
  - `landed` suppresses `colission` and `capture` in that frame.
  - `colission` and `capture` without a landing are both emitted on the same cycle.
- **`lvl_start` outside HOLD.** It clears `points` only; the state is unchanged.

## Timing
- **Pipeline:**
  - Stage 1: positions are registered on the `frame_tick` cycle T.
  - Stage 2: overlap compare at T+1.
  - Stage 3: pulses on outputs at T+2.
- **Latency.** Pulses are high for exactly one cycle, at T+2. `points` updates on the same edge as `capture`.
- **Back-to-back ticks.** `frame_tick` has a minimum spacing of 3 cycles. Closer ticks overwrite stage 1.
- **Reset values.** All outputs are 0, the state is RUN, and the counter and previous-overlap registers are 0.
- **Reset mid-operation.** Reset asserted mid-pipeline discards in-flight frames; no pulse is emitted after deassertion until a new `frame_tick` reaches T+2.

## Configuration
- `GAME_EVENT_INVULN_EN` defined: the INVULN state and counter exist, and `invuln` reflects the state.
- `GAME_EVENT_INVULN_EN` undefined: there is no INVULN state, every qualifying collision edge pulses, and `invuln` is tied to 0.

## Structure
- **Package `game_pkg`:**
  - state enum (RUN, INVULN, HOLD, DEAD);
  - `POINTS_W`=5;
  - `POINTS_FULL`=5'b11111;
  - default `COORD_W`.
- **Sub-module `box_overlap`:** one natural sub-module, parameterised by box sizes. It is combinational and instantiated three times (obstacle, target, pad).

## Test plan
- Player at (100,100) and obstacle at (110,108), then one tick: `colission`=1 at T+2 for 1 cycle and `invuln`=1. The same overlap on the next tick gives no pulse.
- With the macro defined, after a hit move apart and re-overlap at frame 30: no pulse. Re-overlap at frame 61: pulse.
- Five capture edges give `points` 00001→11111. A sixth capture edge gives no `capture` and `points` stays 11111.
- Pad overlap with `landing_en`=0: no `landed`. With `landing_en`=1 and a simultaneous obstacle edge: `landed`=1, `colission`=0, then HOLD; `lvl_start` gives `points`=0 and RUN.
- Player at x=100 and obstacle at x=116 (touching edge): no overlap. Coordinates near 2047+16 do not wrap.
- `fail`=1 gives no pulses for any overlap. Pulling `rst_n` low at T+1 gives all outputs 0 and no pulse at T+2.
